// File: rtl/bitrev_reorder_buf_pkg.sv
// Shared constants and types for the bit-reversal reorder buffer.
package bitrev_pkg;

  localparam int WORD_SIZE = 74;
  localparam int ADDR_SIZE = 5;
  localparam int N         = 1 << ADDR_SIZE;

  typedef logic [WORD_SIZE-1:0] word_t;
  typedef logic [ADDR_SIZE-1:0] addr_t;
  // One count per accepted pair; wraps after N/2 pairs.
  typedef logic [ADDR_SIZE-2:0] pcnt_t;

  typedef logic bank_sel_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_t;

endpackage

// File: rtl/bitrev_reorder_buf_if.sv
// Dual-lane write bus plus streaming output bus of the reorder buffer.
interface bitrev_reorder_buf_if;
  import bitrev_pkg::*;

  logic  i_valid;
  logic  o_ready;
  addr_t i_pipeaddr_A;
  addr_t i_pipeaddr_B;
  word_t i_pipedata_A;
  word_t i_pipedata_B;

  logic  o_valid;
  logic  i_ready;
  word_t o_data;
  addr_t o_index;
  logic  o_last;
  logic  o_collision;

  // Producer of butterfly pairs and consumer of the ordered stream.
  modport master (
    output i_valid, i_pipeaddr_A, i_pipeaddr_B, i_pipedata_A, i_pipedata_B, i_ready,
    input  o_ready, o_valid, o_data, o_index, o_last, o_collision
  );

  // The reorder buffer itself.
  modport slave (
    input  i_valid, i_pipeaddr_A, i_pipeaddr_B, i_pipedata_A, i_pipedata_B, i_ready,
    output o_ready, o_valid, o_data, o_index, o_last, o_collision
  );

endinterface

// File: rtl/bitrev_reorder_buf_bank.sv
// One frame of storage: two write ports (lane B wins on equal address)
// and one registered read port.
module bitrev_bank
  import bitrev_pkg::*;
(
  input  logic  i_CLK,
  input  logic  i_RST,
  input  logic  we,
  input  addr_t addr_a,
  input  word_t data_a,
  input  addr_t addr_b,
  input  word_t data_b,
  input  logic  re,
  input  addr_t rd_addr,
  output word_t rd_data
);

  word_t mem [N];

  // Pair write; B is assigned last so it overrides A on an address clash.
  always_ff @(posedge i_CLK) begin
    if (we) begin
      mem[addr_a] <= data_a;
      mem[addr_b] <= data_b;
    end
  end

  // Registered read; this register is the output data word of the buffer.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      rd_data <= '0;
    end else if (re) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/bitrev_reorder_buf.sv
// Ping-pong reorder buffer: writes tagged pairs into one bank while the
// other bank streams out in natural index order.
//
// state  | meaning
// IDLE   | no frame being read; waits for full[rd_bank], loads index 0 at once
// STREAM | reading rd_bank; loads one word per free/taken output slot
module bitrev_reorder_buf
  import bitrev_pkg::*;
(
  input logic           i_CLK,
  input logic           i_RST,
  bitrev_reorder_buf_if.slave bus
);

  localparam addr_t LAST_IDX = '1;

  rd_state_t state, state_nxt;
  addr_t     rd_idx, rd_idx_nxt;
  bank_sel_t rd_bank, rd_bank_nxt;
  bank_sel_t wr_bank;
  bank_sel_t out_bank;
  pcnt_t     pair_cnt;
  logic [1:0] full, full_nxt;

  logic  accept, frame_done, can_load, load, clr_full;
  logic  valid_q, last_q, coll_q;
  addr_t index_q;
  word_t rd_data0, rd_data1;

  assign bus.o_ready = !full[wr_bank];
  assign accept      = bus.i_valid && bus.o_ready;
  assign frame_done  = accept && (&pair_cnt);
  // The output slot is free when empty or when its word leaves this cycle.
  assign can_load    = !valid_q || bus.i_ready;

  bitrev_bank u_bank0 (
    .i_CLK   (i_CLK),
    .i_RST   (i_RST),
    .we      (accept && !wr_bank),
    .addr_a  (bus.i_pipeaddr_A),
    .data_a  (bus.i_pipedata_A),
    .addr_b  (bus.i_pipeaddr_B),
    .data_b  (bus.i_pipedata_B),
    .re      (load && !rd_bank),
    .rd_addr (rd_idx),
    .rd_data (rd_data0)
  );

  bitrev_bank u_bank1 (
    .i_CLK   (i_CLK),
    .i_RST   (i_RST),
    .we      (accept && wr_bank),
    .addr_a  (bus.i_pipeaddr_A),
    .data_a  (bus.i_pipedata_A),
    .addr_b  (bus.i_pipeaddr_B),
    .data_b  (bus.i_pipedata_B),
    .re      (load && rd_bank),
    .rd_addr (rd_idx),
    .rd_data (rd_data1)
  );

  // Write side: count pairs, close the frame and swap banks on wrap.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      pair_cnt <= '0;
      wr_bank  <= 1'b0;
      coll_q   <= 1'b0;
    end else begin
      if (accept) begin
        pair_cnt <= pair_cnt + pcnt_t'(1);
        if (bus.i_pipeaddr_A == bus.i_pipeaddr_B) coll_q <= 1'b1;
      end
      if (frame_done) wr_bank <= ~wr_bank;
    end
  end

  // Full flags: write side sets, read side clears; the two never target the same bank.
  always_comb begin
    full_nxt = full;
    if (frame_done) full_nxt[wr_bank] = 1'b1;
    if (clr_full)   full_nxt[rd_bank] = 1'b0;
  end

  // Full flag register.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) full <= '0;
    else       full <= full_nxt;
  end

  // Read FSM next state and load decision.
  always_comb begin
    state_nxt   = state;
    rd_idx_nxt  = rd_idx;
    rd_bank_nxt = rd_bank;
    load        = 1'b0;
    clr_full    = 1'b0;
    case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          state_nxt = STREAM;
          if (can_load) begin
            load       = 1'b1;
            rd_idx_nxt = rd_idx + addr_t'(1);
          end
        end
      end
      STREAM: begin
        if (can_load) begin
          load = 1'b1;
          if (rd_idx == LAST_IDX) begin
            clr_full    = 1'b1;
            rd_bank_nxt = ~rd_bank;
            rd_idx_nxt  = '0;
            state_nxt   = IDLE;
          end else begin
            rd_idx_nxt = rd_idx + addr_t'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read FSM registers.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state   <= IDLE;
      rd_idx  <= '0;
      rd_bank <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_idx  <= rd_idx_nxt;
      rd_bank <= rd_bank_nxt;
    end
  end

  // Output register sideband; data itself sits in the selected bank's read register.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      valid_q  <= 1'b0;
      index_q  <= '0;
      last_q   <= 1'b0;
      out_bank <= 1'b0;
    end else if (load) begin
      valid_q  <= 1'b1;
      index_q  <= rd_idx;
      last_q   <= (rd_idx == LAST_IDX);
      out_bank <= rd_bank;
    end else if (valid_q && bus.i_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.o_valid     = valid_q;
  assign bus.o_index     = index_q;
  assign bus.o_last      = last_q;
  assign bus.o_data      = out_bank ? rd_data1 : rd_data0;
  assign bus.o_collision = coll_q;

endmodule

// File: tb/tb_bitrev_reorder_buf.sv
// Scoreboard bench for the bit-reversal reorder buffer.
module tb_bitrev_reorder_buf;
  import bitrev_pkg::*;

  typedef struct packed {
    addr_t idx;
    word_t data;
    logic  last;
  } exp_t;

  logic i_CLK = 1'b0;
  logic i_RST = 1'b1;
  always #5 i_CLK = ~i_CLK;

  bitrev_reorder_buf_if bus();

  bitrev_reorder_buf dut (
    .i_CLK (i_CLK),
    .i_RST (i_RST),
    .bus   (bus)
  );

  int   chks = 0;
  int   errs = 0;
  exp_t exp_q[$];

  // Reference model: frames alternate banks starting at 0; unwritten slots keep old contents.
  word_t model_mem [2][N];
  int    m_wbank = 0;
  int    m_pairs = 0;
  logic  exp_coll = 1'b0;

  addr_t fa [N/2];
  addr_t fb [N/2];
  word_t fda [N/2];
  word_t fdb [N/2];

  int   rdy_mode = 0;
  int   bp_cnt = 0;
  logic idle_gaps = 1'b0;

  int   cyc = 0;
  logic track_gap = 1'b0;
  logic have_prev = 1'b0;
  int   last_hs = 0;
  int   max_gap = 0;

  logic  hold_pend = 1'b0;
  word_t hold_data;
  addr_t hold_idx;
  logic  hold_last;

  function automatic word_t rand_word();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[WORD_SIZE-1:0];
  endfunction

  function automatic addr_t bitrev(input int v);
    addr_t a, r;
    a = addr_t'(v);
    for (int i = 0; i < ADDR_SIZE; i++) r[i] = a[ADDR_SIZE-1-i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_abort(input string name);
    chks++;
    errs++;
    $display("FAIL %s: timed out waiting on DUT", name);
    $display("TB_RESULT checks=%0d failures=%0d", chks, errs);
    $finish;
  endtask

  // kind 0: bit-reversed pairing with data = index; 1: random permutation; 2: collision at slot 7.
  task automatic gen_frame(input int kind);
    int p [N];
    int j, t, pos;
    for (int i = 0; i < N; i++) p[i] = i;
    for (int i = N - 1; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = p[i]; p[i] = p[j]; p[j] = t;
    end
    if (kind == 2) begin
      pos = 0;
      for (int i = 0; i < N; i++) if (p[i] == 7) pos = i;
      t = p[0]; p[0] = p[pos]; p[pos] = t;
    end
    for (int k = 0; k < N/2; k++) begin
      if (kind == 0) begin
        fa[k]  = bitrev(2*k);
        fb[k]  = bitrev(2*k + 1);
        fda[k] = word_t'(fa[k]);
        fdb[k] = word_t'(fb[k]);
      end else begin
        fa[k]  = addr_t'(p[2*k]);
        fb[k]  = addr_t'(p[2*k+1]);
        fda[k] = rand_word();
        fdb[k] = rand_word();
      end
    end
    if (kind == 2) begin
      fa[0]  = addr_t'(7);
      fb[0]  = addr_t'(7);
      fda[0] = word_t'(8'hAA);
      fdb[0] = word_t'(8'hBB);
    end
  endtask

  // Offers one pair until accepted, then applies it to the model; returns 1 time unit after the accepting edge.
  task automatic drive_pair(input int k);
    int waited;
    bus.i_valid      = 1'b1;
    bus.i_pipeaddr_A = fa[k];
    bus.i_pipeaddr_B = fb[k];
    bus.i_pipedata_A = fda[k];
    bus.i_pipedata_B = fdb[k];
    waited = 0;
    while (!bus.o_ready) begin
      if (waited >= 2000) timeout_abort("pair_accept");
      @(posedge i_CLK);
      #1;
      waited++;
    end
    @(posedge i_CLK);
    model_mem[m_wbank][fa[k]] = fda[k];
    model_mem[m_wbank][fb[k]] = fdb[k];
    if (fa[k] == fb[k]) exp_coll = 1'b1;
    m_pairs++;
    if (m_pairs == N/2) begin
      for (int i = 0; i < N; i++)
        exp_q.push_back('{idx: addr_t'(i), data: model_mem[m_wbank][i], last: (i == N - 1)});
      m_wbank = 1 - m_wbank;
      m_pairs = 0;
    end
    #1;
  endtask

  task automatic drive_frame(input int kind);
    gen_frame(kind);
    for (int k = 0; k < N/2; k++) begin
      if (idle_gaps && $urandom_range(3, 0) == 0) begin
        bus.i_valid = 1'b0;
        @(posedge i_CLK);
        #1;
      end
      drive_pair(k);
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int w;
    w = 0;
    while ((exp_q.size() != 0 || bus.o_valid) && w < budget) begin
      @(negedge i_CLK);
      w++;
    end
    chks++;
    if (w >= budget) begin
      errs++;
      $display("FAIL drain: %0d words still expected, o_valid=%0b", exp_q.size(), bus.o_valid);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_o_valid"}, 128'(bus.o_valid), 128'(0));
    chk({tag, "_o_data"}, 128'(bus.o_data), 128'(0));
    chk({tag, "_o_index"}, 128'(bus.o_index), 128'(0));
    chk({tag, "_o_last"}, 128'(bus.o_last), 128'(0));
    chk({tag, "_o_collision"}, 128'(bus.o_collision), 128'(0));
    chk({tag, "_o_ready"}, 128'(bus.o_ready), 128'(1));
  endtask

  // Sink readiness pattern, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge i_CLK);
      #1;
      case (rdy_mode)
        0: bus.i_ready = 1'b0;
        1: bus.i_ready = 1'b1;
        2: begin
          bus.i_ready = (bp_cnt % 4 == 0) || (bp_cnt % 4 == 3);
          bp_cnt++;
        end
        default: bus.i_ready = 1'($urandom_range(1, 0));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handshake, checks held words stay stable.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_CLK);
      cyc++;
      if (hold_pend && !i_RST) begin
        chks++;
        if (!(bus.o_valid && bus.o_data == hold_data && bus.o_index == hold_idx && bus.o_last == hold_last)) begin
          errs++;
          $display("FAIL hold: got valid=%0b idx=%0d data=%0h last=%0b expected valid=1 idx=%0d data=%0h last=%0b",
                   bus.o_valid, bus.o_index, bus.o_data, bus.o_last, hold_idx, hold_data, hold_last);
        end
      end
      hold_pend = 1'b0;
      if (!i_RST && bus.o_valid) begin
        if (bus.i_ready) begin
          chks++;
          if (exp_q.size() == 0) begin
            errs++;
            $display("FAIL out_word: got idx=%0d data=%0h with no word expected", bus.o_index, bus.o_data);
          end else begin
            e = exp_q.pop_front();
            if (bus.o_index != e.idx || bus.o_data != e.data || bus.o_last != e.last) begin
              errs++;
              $display("FAIL out_word: got idx=%0d data=%0h last=%0b expected idx=%0d data=%0h last=%0b",
                       bus.o_index, bus.o_data, bus.o_last, e.idx, e.data, e.last);
            end
          end
          if (track_gap) begin
            if (have_prev && (cyc - last_hs) > max_gap) max_gap = cyc - last_hs;
            have_prev = 1'b1;
            last_hs   = cyc;
          end
        end else begin
          hold_pend = 1'b1;
          hold_data = bus.o_data;
          hold_idx  = bus.o_index;
          hold_last = bus.o_last;
        end
      end
    end
  end

  initial begin
    bus.i_valid      = 1'b0;
    bus.i_pipeaddr_A = '0;
    bus.i_pipeaddr_B = '0;
    bus.i_pipedata_A = '0;
    bus.i_pipedata_B = '0;
    bus.i_ready      = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < N; i++) model_mem[b][i] = '0;

    #12;
    chk_reset_vals("reset");
    @(posedge i_CLK);
    #1;
    i_RST = 1'b0;

    // Directed frame with latency check.
    rdy_mode = 1;
    repeat (2) @(posedge i_CLK);
    #1;
    drive_frame(0);
    chk("latency_before", 128'(bus.o_valid), 128'(0));
    @(posedge i_CLK);
    #1;
    chk("latency_valid", 128'(bus.o_valid), 128'(1));
    chk("latency_index", 128'(bus.o_index), 128'(0));
    chk("latency_data", 128'(bus.o_data), 128'(0));
    wait_drain(200);
    chk("no_collision", 128'(bus.o_collision), 128'(0));

    // Backpressure 1,0,0,1.
    rdy_mode = 2;
    drive_frame(1);
    wait_drain(400);

    // Both banks full.
    rdy_mode = 0;
    drive_frame(1);
    drive_frame(1);
    chk("both_full_ready", 128'(bus.o_ready), 128'(0));
    chk("both_full_valid", 128'(bus.o_valid), 128'(1));
    fork
      drive_frame(1);
      begin
        repeat (20) @(posedge i_CLK);
        #1;
        chk("both_full_ready_hold", 128'(bus.o_ready), 128'(0));
        rdy_mode = 1;
      end
    join
    wait_drain(400);
    chk("ready_after_drain", 128'(bus.o_ready), 128'(1));

    // Continuous streaming.
    rdy_mode  = 1;
    max_gap   = 0;
    have_prev = 1'b0;
    track_gap = 1'b1;
    repeat (4) drive_frame(1);
    wait_drain(400);
    track_gap = 1'b0;
    chks++;
    if (max_gap > 2) begin
      errs++;
      $display("FAIL stream_gap: got max spacing %0d cycles expected at most 2", max_gap);
    end

    // Collision.
    drive_frame(2);
    wait_drain(200);
    chk("collision_set", 128'(bus.o_collision), 128'(exp_coll));

    // Random sink and input gaps.
    rdy_mode  = 3;
    idle_gaps = 1'b1;
    repeat (3) drive_frame(1);
    wait_drain(800);
    idle_gaps = 1'b0;
    chk("collision_sticky", 128'(bus.o_collision), 128'(exp_coll));

    // Reset mid-operation: one frame parked at the output, a partial frame in progress.
    rdy_mode = 0;
    drive_frame(1);
    repeat (2) @(posedge i_CLK);
    #1;
    chk("pre_reset_valid", 128'(bus.o_valid), 128'(1));
    gen_frame(1);
    for (int k = 0; k < 5; k++) drive_pair(k);
    bus.i_valid = 1'b0;
    #3;
    i_RST = 1'b1;
    exp_q.delete();
    m_wbank  = 0;
    m_pairs  = 0;
    exp_coll = 1'b0;
    #1;
    chk_reset_vals("midreset");
    @(posedge i_CLK);
    @(posedge i_CLK);
    #1;
    i_RST = 1'b0;
    chk("ready_after_reset", 128'(bus.o_ready), 128'(1));
    rdy_mode = 1;
    drive_frame(1);
    wait_drain(200);
    rdy_mode = 3;
    drive_frame(1);
    wait_drain(400);
    chk("collision_cleared", 128'(bus.o_collision), 128'(exp_coll));

    $display("TB_RESULT checks=%0d failures=%0d", chks, errs);
    $finish;
  end

endmodule
